pwm_multi_core: RTL and testbench
=================================

Name: pwm_multi_core

Overview:
- Parametrised N-channel successor to the single-channel PWM core. It contains one shared period counter and CH independent duty comparators.
- Period, duty and mode are double-buffered: new values take effect only at a frame boundary, so no glitch is ever produced.
- Supports edge-aligned and center-aligned counting and per-channel external duty override.
- Sits behind the Wishbone register file; its clock comes from the existing clock-select/divider stage.

Parameters:
- CH, 4, number of PWM channels (1..16)
- WIDTH, 16, counter, period and duty width in bits (4..32)

Ports:
- clk  input  1  core clock (divided ext or wb clock)
- rst_n  input  1  asynchronous active-low reset
- en  input  1  core enable; low = idle, counter cleared
- cnt_en  input  1  counter run; low = freeze counter and outputs
- out_en  input  1  output enable; low = o_pwm forced 0, counter keeps running
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
- period  input  WIDTH  frame period value P (shadowed)
- duty  input  CH*WIDTH  per-channel register duty, channel n at [n*WIDTH +: WIDTH]
- duty_sel  input  CH  per-channel select of the external duty
- ext_dc  input  CH*WIDTH  per-channel external duty
- ext_dc_valid  input  CH  per-channel external duty valid
- o_pwm  output  CH  modulated outputs, registered
- o_frame_end  output  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Duty source per channel:
  - ext_dc[n] when duty_sel[n] && ext_dc_valid[n] in the sampling cycle.
  - Otherwise duty[n].
- Shadow load:
  - The active period, mode and CH duties are loaded from the inputs on the clock edge ending a frame-end cycle.
  - They are loaded continuously while en=0.
  - Changing inputs mid-frame has no effect until the next load.
- Edge mode:
  - Counter sequence 0,1,..,P,0; frame length P+1 cycles.
  - Frame-end when cnt==P.
- Center mode:
  - Counter sequence 0 up to P, then down P-1 to 1, then 0; frame length 2P cycles; direction flag dir.
  - Frame-end on the last cycle (dir down and cnt==1, or cnt==P when P==1).
  - At a frame load the counter restarts at 0, direction up.
- P==0 (either mode):
  - Counter stays 0 and frame-end asserts every cycle.
  - o_pwm[n] = (active duty != 0).
- Compare:
  - o_pwm[n] <= out_en & (cnt < duty_act[n]); one-cycle latency from counter to pin.
  - Duty 0 gives a constant 0.
  - Duty > P gives a constant 1 (no clock pass-through).
  - Edge mode: high time = duty cycles per frame when duty <= P.
  - Center mode: high time = 2*duty-1 cycles when 1 <= duty <= P.
- o_frame_end is registered and aligned with the o_pwm sample of the same counter value.
- en=0: counter and dir reset; o_pwm = 0; o_frame_end = 0. Taking effect is synchronous at the next edge.
- cnt_en=0 (with en=1): counter, dir, o_pwm and active registers hold; o_frame_end = 0.
- out_en=0: o_pwm = 0 at the next edge; the counter and frame-end continue normally.
- Reset (rst_n low, at any time including mid-frame):
  - counter, dir, all active registers, o_pwm and o_frame_end are cleared immediately.
  - Restart is at counter 0, edge mode, loaded from the inputs on the first enabled edge.
- Arithmetic: all compares are unsigned WIDTH-bit; the counter never exceeds P, so there is no wrap.

Optional Feature:
- Macro: PWM_DEADTIME_EN
- Defined:
  - Adds parameter DEAD (default 2) and output o_pwm_n [CH], the complementary outputs.
  - Each rising edge of o_pwm[n] or of o_pwm_n[n] is delayed by DEAD cycles after the opposite output falls. Both outputs are never high in the same cycle.
  - Pulses shorter than DEAD are suppressed.
  - o_pwm_n resets to 0.
- Undefined: no o_pwm_n port and no DEAD logic; o_pwm timing is exactly as above.

Test Plan:
- Edge mode, P=9, duty0=3, duty1=0, duty2=10, duty3=9 -> per 10-cycle frame: ch0 high 3 cycles, ch1 always 0, ch2 always 1, ch3 high 9 cycles; o_frame_end pulses every 10 cycles.
- Center mode, P=8, duty0=4 -> frame 16 cycles; ch0 high 7 cycles, symmetric about the cnt==0 point; one frame-end pulse per frame.
- Mid-frame write of P=4, duty0=2 while running P=9 -> the current frame completes with the old values (10 cycles); the next frame is 5 cycles long with a 2-cycle high.
- Channel 1 with duty_sel=1: ext_dc=5 and valid=1 at the frame boundary -> 5 high cycles; valid=0 at the boundary -> falls back to the register duty.
- cnt_en low for 7 cycles mid-frame -> o_pwm and the counter frozen; resuming completes the frame with exactly the remaining cycles. Then out_en=0 -> o_pwm=0 while o_frame_end keeps pulsing.
- rst_n pulsed low mid-frame -> o_pwm and o_frame_end go to 0 asynchronously; after release the counter starts at 0. With PWM_DEADTIME_EN and DEAD=2: o_pwm and o_pwm_n never overlap, with a 2-cycle gap at each transition.

Source files
------------

// File: rtl/pwm_multi_core_if.sv
// Register-side bundle of the multi-channel PWM core.
// Optional PWM_DEADTIME_EN adds the complementary outputs.
interface pwm_multi_core_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 16
);
  logic                en;
  logic                cnt_en;
  logic                out_en;
  logic                center_mode;
  logic [WIDTH-1:0]    period;
  logic [CH*WIDTH-1:0] duty;
  logic [CH-1:0]       duty_sel;
  logic [CH*WIDTH-1:0] ext_dc;
  logic [CH-1:0]       ext_dc_valid;
  logic [CH-1:0]       o_pwm;
  logic                o_frame_end;
`ifdef PWM_DEADTIME_EN
  logic [CH-1:0]       o_pwm_n;
`endif

  modport master (
    output en,
    output cnt_en,
    output out_en,
    output center_mode,
    output period,
    output duty,
    output duty_sel,
    output ext_dc,
    output ext_dc_valid,
`ifdef PWM_DEADTIME_EN
    input  o_pwm_n,
`endif
    input  o_pwm,
    input  o_frame_end
  );

  modport slave (
    input  en,
    input  cnt_en,
    input  out_en,
    input  center_mode,
    input  period,
    input  duty,
    input  duty_sel,
    input  ext_dc,
    input  ext_dc_valid,
`ifdef PWM_DEADTIME_EN
    output o_pwm_n,
`endif
    output o_pwm,
    output o_frame_end
  );
endinterface

// File: rtl/pwm_multi_core.sv
// N-channel PWM core: shared frame counter, shadowed period/mode/duty.
// Define PWM_DEADTIME_EN for complementary outputs with dead time.
module pwm_multi_core #(
  parameter int CH    = 4,
  parameter int WIDTH = 16
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DEAD  = 2
`endif
) (
  input logic             clk,
  input logic             rst_n,
  pwm_multi_core_if.slave bus
);

  typedef logic [WIDTH-1:0] word_t;

  word_t          cnt_q, cnt_d;
  logic           dir_q, dir_d;
  word_t          per_q, per_d;
  logic           mode_q, mode_d;
  word_t          dact_q [CH];
  word_t          dact_d [CH];
  logic           fe_q;
  logic           fe;
  logic           ld;
  logic [CH-1:0]  cmp;

  // Last cycle of the current frame, from the live counter.
  always_comb begin
    fe = 1'b0;
    if (per_q == '0) begin
      fe = 1'b1;
    end else if (!mode_q) begin
      fe = (cnt_q == per_q);
    end else begin
      fe = (dir_q && cnt_q == word_t'(1)) ||
           (per_q == word_t'(1) && cnt_q == per_q);
    end
  end

  // Counter/direction sequencing for edge and center modes.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (fe) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode_q) begin
      cnt_d = cnt_q + word_t'(1);
    end else if (dir_q) begin
      cnt_d = cnt_q - word_t'(1);
    end else if (cnt_q == per_q) begin
      cnt_d = cnt_q - word_t'(1);
      dir_d = 1'b1;
    end else begin
      cnt_d = cnt_q + word_t'(1);
    end
  end

  // Shadow sources; external duty wins only when selected and valid.
  always_comb begin
    per_d  = bus.period;
    mode_d = bus.center_mode;
    for (int n = 0; n < CH; n++) begin
      if (bus.duty_sel[n] && bus.ext_dc_valid[n])
        dact_d[n] = bus.ext_dc[n*WIDTH +: WIDTH];
      else
        dact_d[n] = bus.duty[n*WIDTH +: WIDTH];
    end
  end

  // Shadows follow inputs while idle, else only at a frame end.
  always_comb begin
    ld = !bus.en || (bus.cnt_en && fe);
  end

  // Per-channel compare against the active duty.
  always_comb begin
    cmp = '0;
    for (int n = 0; n < CH; n++)
      cmp[n] = (cnt_q < dact_q[n]);
  end

  // Counter, direction and frame-end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      fe_q  <= 1'b0;
    end else if (!bus.en) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      fe_q  <= 1'b0;
    end else if (bus.cnt_en) begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      fe_q  <= fe;
    end else begin
      fe_q  <= 1'b0;
    end
  end

  // Active (shadowed) period, mode and duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      mode_q <= 1'b0;
      for (int n = 0; n < CH; n++)
        dact_q[n] <= '0;
    end else if (ld) begin
      per_q  <= per_d;
      mode_q <= mode_d;
      for (int n = 0; n < CH; n++)
        dact_q[n] <= dact_d[n];
    end
  end

  assign bus.o_frame_end = fe_q;

`ifdef PWM_DEADTIME_EN
  localparam int RW = $clog2(DEAD + 1) + 1;

  logic [CH-1:0] lvl_q;
  logic [RW-1:0] run_q [CH];
  logic [CH-1:0] pa_q;
  logic [CH-1:0] pb_q;
  logic [CH-1:0] settled;

  // A level may drive a pin once it has been stable long enough.
  always_comb begin
    settled = '0;
    for (int n = 0; n < CH; n++)
      settled[n] = (DEAD == 0) ||
                   ((cmp[n] == lvl_q[n]) &&
                    (run_q[n] >= RW'(DEAD - 1)));
  end

  // Stability tracker and non-overlapping complementary pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      pa_q  <= '0;
      pb_q  <= '0;
      for (int n = 0; n < CH; n++)
        run_q[n] <= '0;
    end else if (!bus.en) begin
      lvl_q <= '0;
      pa_q  <= '0;
      pb_q  <= '0;
      for (int n = 0; n < CH; n++)
        run_q[n] <= '0;
    end else if (bus.cnt_en) begin
      for (int n = 0; n < CH; n++) begin
        if (cmp[n] != lvl_q[n]) begin
          lvl_q[n] <= cmp[n];
          run_q[n] <= '0;
        end else if (run_q[n] < RW'(DEAD)) begin
          run_q[n] <= run_q[n] + RW'(1);
        end
        pa_q[n] <= bus.out_en & cmp[n] & settled[n];
        pb_q[n] <= bus.out_en & ~cmp[n] & settled[n];
      end
    end
  end

  assign bus.o_pwm   = pa_q;
  assign bus.o_pwm_n = pb_q;
`else
  logic [CH-1:0] pwm_q;

  // Registered compare result, gated by the output enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else if (!bus.en) begin
      pwm_q <= '0;
    end else if (bus.cnt_en) begin
      pwm_q <= {CH{bus.out_en}} & cmp;
    end
  end

  assign bus.o_pwm = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_multi_core.sv
// Self-checking bench for pwm_multi_core.
// Per-frame scoreboard of frame length and per-channel high counts.
module tb_pwm_multi_core;
  localparam int CH = 4;
  localparam int W  = 16;

  typedef struct {
    int len;
    int h0;
    int h1;
    int h2;
    int h3;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  pwm_multi_core_if #(.CH(CH), .WIDTH(W)) bus();

  pwm_multi_core #(.CH(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic string fs(frame_t f);
    return $sformatf("len=%0d hi=%0d/%0d/%0d/%0d",
                     f.len, f.h0, f.h1, f.h2, f.h3);
  endfunction

  task automatic set_duty(input int n, input int v);
    bus.duty[n*W +: W] = W'(v);
  endtask

  task automatic push(input int l, input int a, input int b,
                      input int c, input int d);
    frame_t f;
    f.len = l; f.h0 = a; f.h1 = b; f.h2 = c; f.h3 = d;
    exp_q.push_back(f);
  endtask

  // Wait for the next frame-end pulse; an expired bound is a failure.
  task automatic sync_fe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_frame_end && n < 300);
    checks++;
    if (!bus.o_frame_end) begin
      errors++;
      $display("FAIL sync_fe: no frame end in %0d cycles", n);
    end
  endtask

  // Collect one frame: cycles after a pulse up to the next pulse.
  task automatic measure(output frame_t m, output logic [3:0] first,
                         output logic [3:0] last);
    int n;
    n = 0;
    m.len = 0; m.h0 = 0; m.h1 = 0; m.h2 = 0; m.h3 = 0;
    first = '0;
    last = '0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) first = bus.o_pwm;
      last = bus.o_pwm;
      m.h0 += int'(bus.o_pwm[0]);
      m.h1 += int'(bus.o_pwm[1]);
      m.h2 += int'(bus.o_pwm[2]);
      m.h3 += int'(bus.o_pwm[3]);
    end while (!bus.o_frame_end && n < 200);
    m.len = bus.o_frame_end ? n : -1;
  endtask

  task automatic test_reset();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    bus.en = 1'b1; bus.cnt_en = 1'b1; bus.out_en = 1'b1;
    bus.center_mode = 1'b0;
    bus.period = W'(9);
    bus.duty = '0; bus.ext_dc = '0;
    bus.duty_sel = '0; bus.ext_dc_valid = '0;
    set_duty(0, 3); set_duty(1, 0); set_duty(2, 10); set_duty(3, 9);
    #12;
    checks++;
    if (bus.o_pwm !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pwm: got %b want 0000", bus.o_pwm);
    end
    checks++;
    if (bus.o_frame_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_fe: got %b want 0", bus.o_frame_end);
    end
    rst_n = 1'b1;
    sync_fe(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL reset_first_fe: got %0d cycles want 1", n);
    end
    push(10, 3, 0, 10, 9);
    measure(m, f, l);
    e = exp_q.pop_front();
    checks++;
    if (m != e) begin
      errors++;
      $display("FAIL reset_frame: got %s want %s", fs(m), fs(e));
    end
  endtask

  task automatic test_edge();
    frame_t m, e;
    logic [3:0] f, l;
    push(10, 3, 0, 10, 9);
    push(10, 3, 0, 10, 9);
    for (int i = 0; i < 2; i++) begin
      measure(m, f, l);
      e = exp_q.pop_front();
      checks++;
      if (m != e) begin
        errors++;
        $display("FAIL edge_frame%0d: got %s want %s", i, fs(m), fs(e));
      end
    end
  endtask

  task automatic test_center();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    bus.center_mode = 1'b1;
    bus.period = W'(8);
    set_duty(0, 4); set_duty(1, 0); set_duty(2, 9); set_duty(3, 8);
    sync_fe(n);
    push(16, 7, 0, 16, 15);
    push(16, 7, 0, 16, 15);
    for (int i = 0; i < 2; i++) begin
      measure(m, f, l);
      e = exp_q.pop_front();
      checks++;
      if (m != e) begin
        errors++;
        $display("FAIL center_frame%0d: got %s want %s",
                 i, fs(m), fs(e));
      end
      checks++;
      if (f[1:0] !== 2'b01 || l[1:0] !== 2'b01) begin
        errors++;
        $display("FAIL center_sym%0d: first=%b last=%b want 01/01",
                 i, f[1:0], l[1:0]);
      end
    end
  endtask

  task automatic test_midframe();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    bus.center_mode = 1'b0;
    bus.period = W'(9);
    set_duty(0, 3); set_duty(1, 0); set_duty(2, 10); set_duty(3, 9);
    sync_fe(n);
    push(10, 3, 0, 10, 9);
    push(5, 2, 0, 5, 5);
    fork
      measure(m, f, l);
      begin
        repeat (4) @(negedge clk);
        bus.period = W'(4);
        set_duty(0, 2);
      end
    join
    for (int i = 0; i < 2; i++) begin
      if (i == 1) measure(m, f, l);
      e = exp_q.pop_front();
      checks++;
      if (m != e) begin
        errors++;
        $display("FAIL mid_frame%0d: got %s want %s", i, fs(m), fs(e));
      end
    end
  endtask

  task automatic test_ext();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    bus.period = W'(9);
    set_duty(1, 2);
    bus.duty_sel = 4'b0010;
    bus.ext_dc[1*W +: W] = W'(5);
    bus.ext_dc_valid = 4'b0010;
    sync_fe(n);
    push(10, 2, 5, 10, 9);
    push(10, 2, 2, 10, 9);
    fork
      measure(m, f, l);
      begin
        repeat (3) @(negedge clk);
        bus.ext_dc_valid = 4'b0000;
      end
    join
    for (int i = 0; i < 2; i++) begin
      if (i == 1) measure(m, f, l);
      e = exp_q.pop_front();
      checks++;
      if (m != e) begin
        errors++;
        $display("FAIL ext_frame%0d: got %s want %s", i, fs(m), fs(e));
      end
    end
  endtask

  task automatic test_freeze();
    frame_t m, e;
    logic [3:0] f, l;
    push(17, 2, 2, 17, 16);
    fork
      measure(m, f, l);
      begin
        repeat (4) @(negedge clk);
        bus.cnt_en = 1'b0;
        repeat (7) @(negedge clk);
        bus.cnt_en = 1'b1;
      end
    join
    e = exp_q.pop_front();
    checks++;
    if (m != e) begin
      errors++;
      $display("FAIL freeze_frame: got %s want %s", fs(m), fs(e));
    end
    bus.out_en = 1'b0;
    push(10, 0, 0, 0, 0);
    measure(m, f, l);
    e = exp_q.pop_front();
    checks++;
    if (m != e) begin
      errors++;
      $display("FAIL out_en_frame: got %s want %s", fs(m), fs(e));
    end
    bus.out_en = 1'b1;
  endtask

  task automatic test_pzero();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    bus.period = '0;
    set_duty(0, 0);
    measure(m, f, l);
    for (int i = 0; i < 3; i++) push(1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      measure(m, f, l);
      e = exp_q.pop_front();
      checks++;
      if (m != e) begin
        errors++;
        $display("FAIL pzero_frame%0d: got %s want %s",
                 i, fs(m), fs(e));
      end
    end
    bus.period = W'(9);
    set_duty(0, 3);
    sync_fe(n);
  endtask

  task automatic test_reset_mid();
    frame_t m, e;
    logic [3:0] f, l;
    int n;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_pwm !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_pwm: got %b want 0000", bus.o_pwm);
    end
    checks++;
    if (bus.o_frame_end !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fe: got %b want 0", bus.o_frame_end);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    sync_fe(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL rst_mid_first_fe: got %0d cycles want 1", n);
    end
    push(10, 3, 2, 10, 9);
    measure(m, f, l);
    e = exp_q.pop_front();
    checks++;
    if (m != e) begin
      errors++;
      $display("FAIL rst_mid_frame: got %s want %s", fs(m), fs(e));
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_midframe();
    test_ext();
    test_freeze();
    test_pzero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
